// File: rtl/decoder_scoreboard.sv
// Register write scoreboard: one-hot decodes issue and writeback selects, keeps a
// busy bit per architectural register and reports read/issue hazards to decode.
module decoder_scoreboard #(
    parameter int SEL_WIDTH      = 5,
    parameter int NUM_READ       = 2,
    parameter int ZERO_HARDWIRED = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          issue_en,
    input  logic [SEL_WIDTH-1:0]          issue_sel,
    input  logic                          wb_en,
    input  logic [SEL_WIDTH-1:0]          wb_sel,
    input  logic [NUM_READ*SEL_WIDTH-1:0] rd_sel,
    output logic [NUM_READ-1:0]           rd_busy,
    output logic                          issue_stall,
    output logic [(2**SEL_WIDTH)-1:0]     issue_onehot,
    output logic [(2**SEL_WIDTH)-1:0]     busy_vec,
    output logic [SEL_WIDTH:0]            busy_count,
    output logic                          wb_err
);

    localparam int   NUM_REGS = 2**SEL_WIDTH;
    localparam logic ZERO_HW  = (ZERO_HARDWIRED != 0);

    // Issue handshake: issue_en is the request (valid); the request is taken on the
    // rising edge unless issue_stall is high in that cycle (ready = ~issue_stall).
    // A stalled request is not remembered; the requester simply retries.
    logic                 wb_hit;
    logic                 wb_miss;
    logic                 issue_acc;
    logic [NUM_REGS-1:0]  dec_wb;
    logic [NUM_REGS-1:0]  dec_issue;
    logic [NUM_REGS-1:0]  busy_next;
    logic [SEL_WIDTH:0]   count_next;
    logic [SEL_WIDTH-1:0] rd_sel_k;

    always_comb begin
        wb_hit      = wb_en & busy_vec[wb_sel];
        wb_miss     = wb_en & ~busy_vec[wb_sel] & ~(ZERO_HW & (wb_sel == '0));
        // A writeback to the same register this cycle frees it first, so issue proceeds.
        issue_stall = issue_en & busy_vec[issue_sel] & ~(wb_hit & (wb_sel == issue_sel));
        issue_acc   = issue_en & ~issue_stall & ~(ZERO_HW & (issue_sel == '0));

        dec_wb    = '0;
        dec_issue = '0;
        if (wb_hit)    dec_wb[wb_sel]       = 1'b1;
        if (issue_acc) dec_issue[issue_sel] = 1'b1;

        busy_next  = (busy_vec & ~dec_wb) | dec_issue;
        count_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            count_next = count_next + (SEL_WIDTH+1)'(busy_next[i]);
        end

        // Writeback data is forwarded, so a register written back this cycle reads as ready.
        rd_busy  = '0;
        rd_sel_k = '0;
        for (int k = 0; k < NUM_READ; k++) begin
            rd_sel_k   = rd_sel[k*SEL_WIDTH +: SEL_WIDTH];
            rd_busy[k] = busy_vec[rd_sel_k] & ~(wb_hit & (wb_sel == rd_sel_k))
                       & ~(ZERO_HW & (rd_sel_k == '0));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_vec     <= '0;
            issue_onehot <= '0;
            busy_count   <= '0;
            wb_err       <= 1'b0;
        end else begin
            busy_vec     <= busy_next;
            issue_onehot <= dec_issue;
            busy_count   <= count_next;
            if (wb_miss) wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_decoder_scoreboard.sv
// Bench for decoder_scoreboard: directed scenarios plus random traffic, checked
// against a register-level behavioural model of the scoreboard.
module tb_decoder_scoreboard;

    localparam int SW   = 5;
    localparam int NR   = 2;
    localparam int NREG = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              issue_en;
    logic [SW-1:0]     issue_sel;
    logic              wb_en;
    logic [SW-1:0]     wb_sel;
    logic [NR*SW-1:0]  rd_sel;
    logic [NR-1:0]     rd_busy;
    logic              issue_stall;
    logic [NREG-1:0]   issue_onehot;
    logic [NREG-1:0]   busy_vec;
    logic [SW:0]       busy_count;
    logic              wb_err;

    int errors = 0;
    int checks = 0;

    // reference model state
    bit              m_busy[NREG];
    bit              m_err;
    logic [NREG-1:0] m_onehot;

    decoder_scoreboard #(.SEL_WIDTH(SW), .NUM_READ(NR), .ZERO_HARDWIRED(1)) dut (
        .clock(clock), .reset(reset),
        .issue_en(issue_en), .issue_sel(issue_sel),
        .wb_en(wb_en), .wb_sel(wb_sel), .rd_sel(rd_sel),
        .rd_busy(rd_busy), .issue_stall(issue_stall), .issue_onehot(issue_onehot),
        .busy_vec(busy_vec), .busy_count(busy_count), .wb_err(wb_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG-1:0] m_vec();
        logic [NREG-1:0] v = '0;
        for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        m_err    = 1'b0;
        m_onehot = '0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".busy_vec"},     busy_vec,     m_vec());
        chk({tag, ".issue_onehot"}, issue_onehot, m_onehot);
        chk({tag, ".busy_count"},   busy_count,   m_count());
        chk({tag, ".wb_err"},       wb_err,       m_err);
    endtask

    // Called at a falling edge: drives one cycle of inputs, checks the combinational
    // outputs, clocks once and checks the registered state at the next falling edge.
    task automatic step(input bit ie, input int isel, input bit we, input int wsel,
                        input int r0, input int r1,
                        output logic [NR-1:0] obs_rd, output logic obs_stall);
        bit wb_hit, stall, acc;
        logic [NR-1:0] exp_rd;
        int rs[NR];
        issue_en  = ie;
        issue_sel = isel[SW-1:0];
        wb_en     = we;
        wb_sel    = wsel[SW-1:0];
        rd_sel    = {r1[SW-1:0], r0[SW-1:0]};
        rs[0] = r0;
        rs[1] = r1;
        #1;
        wb_hit = we && m_busy[wsel];
        stall  = ie && m_busy[isel] && !(wb_hit && wsel == isel);
        acc    = ie && !stall && isel != 0;
        for (int k = 0; k < NR; k++)
            exp_rd[k] = rs[k] != 0 && m_busy[rs[k]] && !(wb_hit && wsel == rs[k]);
        obs_rd    = rd_busy;
        obs_stall = issue_stall;
        chk("rd_busy", rd_busy, exp_rd);
        chk("issue_stall", issue_stall, stall);
        if (we && !m_busy[wsel] && wsel != 0) m_err = 1'b1;
        if (wb_hit) m_busy[wsel] = 1'b0;
        if (acc) m_busy[isel] = 1'b1;
        m_onehot = acc ? (NREG'(1) << isel) : '0;
        @(posedge clock);
        @(negedge clock);
        chk_state("step");
    endtask

    logic [NR-1:0] o_rd;
    logic          o_st;

    initial begin
        reset = 1'b1;
        issue_en = 1'b0; issue_sel = '0; wb_en = 1'b0; wb_sel = '0; rd_sel = '0;
        m_clear();
        #1;
        chk_state("reset");
        chk("reset.rd_busy", rd_busy, 2'b00);
        chk("reset.issue_stall", issue_stall, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // single issue: latency-1 one-hot pulse
        step(1, 5, 0, 0, 0, 0, o_rd, o_st);
        chk("t2.busy_vec", busy_vec, 32'h20);
        chk("t2.onehot", issue_onehot, 32'h20);
        chk("t2.count", busy_count, 1);
        step(0, 0, 0, 0, 0, 0, o_rd, o_st);
        chk("t2.onehot_clear", issue_onehot, 0);

        // re-issue to busy register stalls
        step(1, 5, 0, 0, 5, 0, o_rd, o_st);
        chk("t3.stall", o_st, 1'b1);
        chk("t3.busy_vec", busy_vec, 32'h20);
        chk("t3.onehot", issue_onehot, 0);

        // same-cycle writeback frees it first
        step(1, 5, 1, 5, 0, 0, o_rd, o_st);
        chk("t4.stall", o_st, 1'b0);
        chk("t4.onehot", issue_onehot, 32'h20);
        chk("t4.busy_vec", busy_vec, 32'h20);
        chk("t4.count", busy_count, 1);

        // read-port bypass
        step(1, 7, 0, 0, 0, 0, o_rd, o_st);
        step(0, 0, 1, 7, 7, 3, o_rd, o_st);
        chk("t5.rd_bypass", o_rd, 2'b00);
        step(1, 7, 0, 0, 0, 0, o_rd, o_st);
        step(0, 0, 0, 0, 7, 3, o_rd, o_st);
        chk("t5.rd_busy", o_rd, 2'b01);
        step(1, 7, 0, 0, 3, 7, o_rd, o_st);
        chk("t5.rd_issue_no_effect", o_rd, 2'b10);

        // register 0 and writeback errors
        step(1, 0, 0, 0, 0, 0, o_rd, o_st);
        chk("t6.r0_stall", o_st, 1'b0);
        chk("t6.r0_busy", busy_vec[0], 1'b0);
        chk("t6.r0_onehot", issue_onehot, 0);
        step(0, 0, 1, 0, 0, 0, o_rd, o_st);
        chk("t6.wb0_no_err", wb_err, 1'b0);
        step(0, 0, 1, 9, 0, 0, o_rd, o_st);
        chk("t6.wb_err", wb_err, 1'b1);
        step(0, 0, 0, 0, 0, 0, o_rd, o_st);
        chk("t6.wb_err_sticky", wb_err, 1'b1);

        // random traffic
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, NREG-1),
                 $urandom_range(0, 3) != 0, $urandom_range(0, NREG-1),
                 $urandom_range(0, NREG-1), $urandom_range(0, NREG-1), o_rd, o_st);
        end

        // fill every non-zero register
        for (int i = 1; i < NREG; i++) step(1, i, 0, 0, i, 0, o_rd, o_st);
        step(1, 0, 0, 0, 0, 0, o_rd, o_st);
        chk("t6.full_vec", busy_vec, 32'hFFFF_FFFE);
        chk("t6.full_count", busy_count, 31);
        chk("t6.err_still_set", wb_err, 1'b1);

        // async reset mid-run with r4..r7 busy
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_clear();
        for (int i = 4; i < 8; i++) step(1, i, 0, 0, 0, 0, o_rd, o_st);
        step(0, 0, 0, 0, 0, 0, o_rd, o_st);
        chk("t1.pre_vec", busy_vec, 32'hF0);
        issue_en = 1'b1; issue_sel = 5'd5; rd_sel = {5'd6, 5'd5};
        #1;
        reset = 1'b1;
        #1;
        m_clear();
        chk_state("t1.async");
        chk("t1.rd_busy", rd_busy, 2'b00);
        chk("t1.issue_stall", issue_stall, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step($urandom_range(0, 1), $urandom_range(0, NREG-1),
                 $urandom_range(0, 1), $urandom_range(0, NREG-1),
                 $urandom_range(0, NREG-1), $urandom_range(0, NREG-1), o_rd, o_st);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
